byte_unpack: RTL and testbench

- Decoder-side inverse of the encoder's byte packer.
- Accepts the 32-bit JPEG entropy-coded byte stream and removes 0xFF00 byte stuffing.
- Detects markers (RSTn, EOI, other) and presents an MSB-first 32-bit bit-window to the downstream Huffman decoder.
- The downstream decoder consumes 0..32 bits per cycle.

---
 rtl/jdec_pkg.sv | 32 +++
 rtl/byte_unstuff.sv | 72 +++++++
 rtl/byte_unpack.sv | 141 ++++++++++++++
 tb/tb_byte_unpack.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/jdec_pkg.sv
// Shared JPEG decoder definitions: marker codes, byte-mask type and small helpers.
package jdec_pkg;

  localparam logic [7:0] M_STUFF = 8'h00;
  localparam logic [7:0] M_FILL  = 8'hFF;
  localparam logic [7:0] M_RST0  = 8'hD0;
  localparam logic [7:0] M_RST1  = 8'hD1;
  localparam logic [7:0] M_RST2  = 8'hD2;
  localparam logic [7:0] M_RST3  = 8'hD3;
  localparam logic [7:0] M_RST4  = 8'hD4;
  localparam logic [7:0] M_RST5  = 8'hD5;
  localparam logic [7:0] M_RST6  = 8'hD6;
  localparam logic [7:0] M_RST7  = 8'hD7;
  localparam logic [7:0] M_EOI   = 8'hD9;

  // Bit 3 marks the first stream byte (word[31:24]), bit 0 the last.
  typedef logic [3:0] byte_mask_t;

  function automatic logic is_rst(input logic [7:0] code);
    return (code >= M_RST0) && (code <= M_RST7);
  endfunction

  function automatic byte_mask_t mask_from_count(input logic [2:0] n);
    case (n)
      3'd1:    return 4'b1000;
      3'd2:    return 4'b1100;
      3'd3:    return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/byte_unstuff.sv
// Combinational 0xFF00 unstuffer for one 32-bit word: packs surviving bytes
// left-justified and stops at the first marker byte.
module byte_unstuff
  import jdec_pkg::*;
(
  input  logic [31:0] word,
  input  byte_mask_t  mask,
  input  logic        prev_ff,
  output logic [31:0] packed_bytes,
  output logic [2:0]  byte_count,
  output byte_mask_t  mask_next,
  output logic        prev_ff_next,
  output logic        marker_hit,
  output logic [7:0]  marker_code
);

  logic [7:0] lane [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = word[31-8*gi -: 8];
  end

  logic       ff_c;
  logic       stop_c;
  logic       emit_c;
  logic [7:0] val_c;

  always_comb begin
    packed_bytes = '0;
    byte_count   = '0;
    mask_next    = mask;
    prev_ff_next = prev_ff;
    marker_hit   = 1'b0;
    marker_code  = '0;
    ff_c         = prev_ff;
    stop_c       = 1'b0;
    emit_c       = 1'b0;
    val_c        = '0;
    for (int i = 0; i < 4; i++) begin
      emit_c = 1'b0;
      val_c  = lane[i];
      if (mask[3-i] && !stop_c) begin
        mask_next[3-i] = 1'b0;
        if (!ff_c) begin
          if (lane[i] == M_FILL) ff_c = 1'b1;
          else emit_c = 1'b1;
        end else if (lane[i] == M_STUFF) begin
          emit_c = 1'b1;
          val_c  = M_FILL;
          ff_c   = 1'b0;
        end else if (lane[i] != M_FILL) begin
          // Marker: later bytes keep their mask bits until the marker is acked.
          stop_c      = 1'b1;
          marker_hit  = 1'b1;
          marker_code = lane[i];
          ff_c        = 1'b0;
        end
      end
      if (emit_c) begin
        case (byte_count)
          3'd0:    packed_bytes[31:24] = val_c;
          3'd1:    packed_bytes[23:16] = val_c;
          3'd2:    packed_bytes[15:8]  = val_c;
          default: packed_bytes[7:0]   = val_c;
        endcase
        byte_count = byte_count + 3'd1;
      end
    end
    prev_ff_next = ff_c;
  end

endmodule

// File: rtl/byte_unpack.sv
// JPEG entropy-stream byte unpacker: word register, unstuffing, MSB-first bit
// buffer with variable consume, and marker / end-of-scan control.
module byte_unpack
  import jdec_pkg::*;
#(
  parameter int BUF_W = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] in_data,
  input  logic [2:0]  in_bytes,
  input  logic        in_tlast,
  input  logic        in_valid,
  output logic        in_hold,
  output logic [31:0] out_window,
  output logic [6:0]  out_bits,
  output logic        out_last,
  input  logic        consume_valid,
  input  logic [5:0]  consume_len,
  output logic        out_marker_valid,
  output logic [7:0]  out_marker,
  input  logic        marker_ack
);

  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam logic [FILL_W-1:0] SPACE_LIMIT = FILL_W'(BUF_W - 32);

  logic [31:0]       word_reg;
  byte_mask_t        mask_reg;
  logic              tlast_reg;
  logic              prev_ff_reg;
  logic [BUF_W-1:0]  buf_reg, buf_next;
  logic [FILL_W-1:0] fill_reg, fill_next;
  logic              mpend_reg;
  logic [7:0]        marker_reg;
  logic              last_reg, last_next;
  logic              prev_ff_next;

  logic [31:0]       us_bytes;
  logic [2:0]        us_count;
  byte_mask_t        us_mask;
  logic              us_prev_ff;
  logic              us_hit;
  logic [7:0]        us_code;

  logic              load;
  logic              proceed;
  logic              acked;
  logic              word_done;
  logic [FILL_W-1:0] consume_amt;
  logic [FILL_W-1:0] fill_after;

  byte_unstuff u_unstuff (
    .word         (word_reg),
    .mask         (mask_reg),
    .prev_ff      (prev_ff_reg),
    .packed_bytes (us_bytes),
    .byte_count   (us_count),
    .mask_next    (us_mask),
    .prev_ff_next (us_prev_ff),
    .marker_hit   (us_hit),
    .marker_code  (us_code)
  );

  assign consume_amt = consume_valid ? FILL_W'(consume_len) : '0;
  assign fill_after  = fill_reg - consume_amt;
  assign acked       = mpend_reg && marker_ack;
  assign in_hold     = (mask_reg != '0) || mpend_reg;
  assign load        = in_valid && !in_hold;
  // A word is only unstuffed when a full 32 bits of space remain, so the
  // append never has to be split across cycles.
  assign proceed     = (mask_reg != '0) && !mpend_reg && (fill_after <= SPACE_LIMIT);
  assign word_done   = proceed && tlast_reg && (us_mask == '0);

  always_comb begin
    buf_next  = buf_reg << consume_amt;
    fill_next = fill_after;
    if (acked) begin
      buf_next  = '0;
      fill_next = '0;
    end else if (proceed) begin
      buf_next  = buf_next | ({us_bytes, {(BUF_W-32){1'b0}}} >> fill_after);
      fill_next = fill_after + FILL_W'({us_count, 3'b000});
    end
  end

  always_comb begin
    prev_ff_next = prev_ff_reg;
    if (proceed) prev_ff_next = word_done ? 1'b0 : us_prev_ff;
  end

  always_comb begin
    last_next = last_reg;
    if (word_done) last_next = 1'b1;
    else if (last_reg && (fill_reg == '0) && (!mpend_reg || marker_ack)) last_next = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      word_reg    <= '0;
      mask_reg    <= '0;
      tlast_reg   <= 1'b0;
      prev_ff_reg <= 1'b0;
      buf_reg     <= '0;
      fill_reg    <= '0;
      mpend_reg   <= 1'b0;
      marker_reg  <= '0;
      last_reg    <= 1'b0;
    end else begin
      if (load) begin
        word_reg  <= in_data;
        mask_reg  <= mask_from_count(in_bytes);
        tlast_reg <= in_tlast;
      end else if (proceed) begin
        mask_reg  <= us_mask;
      end
      prev_ff_reg <= prev_ff_next;
      if (proceed && us_hit) begin
        mpend_reg  <= 1'b1;
        marker_reg <= us_code;
      end else if (acked) begin
        mpend_reg  <= 1'b0;
      end
      buf_reg  <= buf_next;
      fill_reg <= fill_next;
      last_reg <= last_next;
    end
  end

  assign out_window       = buf_reg[BUF_W-1 -: 32];
  assign out_bits         = 7'(fill_reg);
  assign out_last         = last_reg;
  assign out_marker_valid = mpend_reg;
  assign out_marker       = marker_reg;

  a_consume_len: assert property (@(posedge clk) disable iff (!resetn)
    consume_valid |-> (consume_len <= 6'd32) && ({1'b0, consume_len} <= out_bits));
  a_in_bytes: assert property (@(posedge clk) disable iff (!resetn)
    in_valid |-> (in_bytes >= 3'd1) && (in_bytes <= 3'd4) && (in_tlast || (in_bytes == 3'd4)));

endmodule

// File: tb/tb_byte_unpack.sv
// Directed bench for byte_unpack: unstuffing, cross-word stuffing, markers,
// end-of-scan handling and asynchronous reset.
module tb_byte_unpack;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] in_data;
  logic [2:0]  in_bytes;
  logic        in_tlast;
  logic        in_valid;
  logic        in_hold;
  logic [31:0] out_window;
  logic [6:0]  out_bits;
  logic        out_last;
  logic        consume_valid;
  logic [5:0]  consume_len;
  logic        out_marker_valid;
  logic [7:0]  out_marker;
  logic        marker_ack;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  byte_unpack #(.BUF_W(64)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .in_data          (in_data),
    .in_bytes         (in_bytes),
    .in_tlast         (in_tlast),
    .in_valid         (in_valid),
    .in_hold          (in_hold),
    .out_window       (out_window),
    .out_bits         (out_bits),
    .out_last         (out_last),
    .consume_valid    (consume_valid),
    .consume_len      (consume_len),
    .out_marker_valid (out_marker_valid),
    .out_marker       (out_marker),
    .marker_ack       (marker_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
    int t;
    in_data  = d;
    in_bytes = nb;
    in_tlast = last;
    in_valid = 1'b1;
    t = 0;
    while (in_hold && t < 20) begin
      step(1);
      t++;
    end
    check("send_accept", 32'(t < 20), 32'd1);
    step(1);
    in_valid = 1'b0;
    in_tlast = 1'b0;
    $display("tb: word %h bytes=%0d tlast=%0d sent", d, nb, last);
  endtask

  task automatic consume(input int n);
    consume_valid = 1'b1;
    consume_len   = 6'(n);
    step(1);
    consume_valid = 1'b0;
    consume_len   = '0;
    $display("tb: consumed %0d bits", n);
  endtask

  task automatic ack();
    marker_ack = 1'b1;
    step(1);
    marker_ack = 1'b0;
    $display("tb: marker ack");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_bytes [8];
    exp_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

    resetn        = 1'b0;
    in_data       = '0;
    in_bytes      = 3'd4;
    in_tlast      = 1'b0;
    in_valid      = 1'b0;
    consume_valid = 1'b0;
    consume_len   = '0;
    marker_ack    = 1'b0;
    step(3);
    check("rst_in_hold", 32'(in_hold), 32'd0);
    check("rst_out_bits", 32'(out_bits), 32'd0);
    check("rst_window", out_window, 32'h0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_mvalid", 32'(out_marker_valid), 32'd0);
    check("rst_marker", 32'(out_marker), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    step(1);

    // Plain data, 8 bits consumed per cycle.
    send_word(32'h12345678, 3'd4, 1'b0);
    step(1);
    check("w1_bits", 32'(out_bits), 32'd32);
    check("w1_window", out_window, 32'h12345678);
    send_word(32'h9ABCDEF0, 3'd4, 1'b0);
    step(1);
    check("w2_bits", 32'(out_bits), 32'd64);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("byte%0d", i), 32'(out_window[31:24]), 32'(exp_bytes[i]));
      consume(8);
    end
    check("plain_drain_bits", 32'(out_bits), 32'd0);
    check("plain_drain_window", out_window, 32'h0);

    // In-word stuffing.
    send_word(32'hFF00AB00, 3'd4, 1'b0);
    step(1);
    check("stuff_bits", 32'(out_bits), 32'd24);
    check("stuff_window", out_window, 32'hFFAB0000);
    consume(24);
    check("stuff_drain", 32'(out_bits), 32'd0);

    // Stuffing split across a word boundary.
    send_word(32'h112233FF, 3'd4, 1'b0);
    step(1);
    check("xw1_bits", 32'(out_bits), 32'd24);
    check("xw1_window", out_window, 32'h11223300);
    send_word(32'h00445566, 3'd4, 1'b0);
    step(1);
    check("xw2_bits", 32'(out_bits), 32'd56);
    check("xw2_window", out_window, 32'h112233FF);
    consume(32);
    check("xw_tail_bits", 32'(out_bits), 32'd24);
    check("xw_tail_window", out_window, 32'h44556600);
    consume(24);

    // RST marker mid-word, data after it resumes on ack.
    send_word(32'hA1FFD0B2, 3'd4, 1'b0);
    step(1);
    check("mk_bits", 32'(out_bits), 32'd8);
    check("mk_window", out_window, 32'hA1000000);
    check("mk_valid", 32'(out_marker_valid), 32'd1);
    check("mk_code", 32'(out_marker), 32'hD0);
    check("mk_hold", 32'(in_hold), 32'd1);
    step(2);
    check("mk_stalled_bits", 32'(out_bits), 32'd8);
    ack();
    check("mk_ack_bits", 32'(out_bits), 32'd0);
    check("mk_ack_valid", 32'(out_marker_valid), 32'd0);
    step(1);
    check("mk_resume_bits", 32'(out_bits), 32'd8);
    check("mk_resume_window", out_window, 32'hB2000000);
    check("mk_resume_hold", 32'(in_hold), 32'd0);
    consume(8);

    // EOI with fill bytes on the last word of the scan.
    send_word(32'h7FFFFFD9, 3'd4, 1'b1);
    step(1);
    check("eoi_bits", 32'(out_bits), 32'd8);
    check("eoi_window", out_window, 32'h7F000000);
    check("eoi_valid", 32'(out_marker_valid), 32'd1);
    check("eoi_code", 32'(out_marker), 32'hD9);
    check("eoi_last", 32'(out_last), 32'd1);
    consume(8);
    check("eoi_last_held", 32'(out_last), 32'd1);
    ack();
    check("eoi_last_clear", 32'(out_last), 32'd0);
    check("eoi_valid_clear", 32'(out_marker_valid), 32'd0);
    check("eoi_idle_hold", 32'(in_hold), 32'd0);

    // Dangling FF at tlast must not stuff the next scan's leading 00.
    send_word(32'h5566FF00, 3'd3, 1'b1);
    step(1);
    check("dang_bits", 32'(out_bits), 32'd16);
    check("dang_window", out_window, 32'h55660000);
    check("dang_last", 32'(out_last), 32'd1);
    consume(16);
    step(1);
    check("dang_last_clear", 32'(out_last), 32'd0);
    send_word(32'h00112233, 3'd4, 1'b0);
    step(1);
    check("dang_next_bits", 32'(out_bits), 32'd32);
    check("dang_next_window", out_window, 32'h00112233);
    consume(32);

    // Asynchronous reset with data buffered and a marker pending.
    send_word(32'hAABBCCDD, 3'd4, 1'b0);
    step(1);
    send_word(32'hEEFFD311, 3'd4, 1'b0);
    step(1);
    check("pre_rst_bits", 32'(out_bits), 32'd40);
    check("pre_rst_valid", 32'(out_marker_valid), 32'd1);
    check("pre_rst_code", 32'(out_marker), 32'hD3);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_bits", 32'(out_bits), 32'd0);
    check("arst_valid", 32'(out_marker_valid), 32'd0);
    check("arst_hold", 32'(in_hold), 32'd0);
    check("arst_window", out_window, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    step(1);
    send_word(32'h01020304, 3'd4, 1'b0);
    step(1);
    check("post_rst_bits", 32'(out_bits), 32'd32);
    check("post_rst_window", out_window, 32'h01020304);
    check("post_rst_valid", 32'(out_marker_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
